highscore_ctrl: RTL and testbench
=================================

# highscore_ctrl

Sequencer for the score/high-score path of the game. It counts the running 4-digit BCD score during play. On game over it runs a timed compare of the final score against the stored high score and commits the score as the new high score only when it is strictly greater. It sits between the game-state logic (start, point and game-over pulses) and the seven-segment display drivers, which read both digit sets.

## Interface
- No parameters; digit count fixed at 4, each digit BCD 0–9.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- start  in  1  one-cycle pulse; begin new game
- point  in  1  one-cycle pulse; score +1
- game_over  in  1  one-cycle pulse; end of game
- clear_hi  in  1  one-cycle pulse; zero the high score
- score0..score3  out  4 each  running score, BCD, score3 most significant
- hi0..hi3  out  4 each  stored high score, BCD, hi3 most significant
- new_hi  out  1  high score was replaced by the last game
- busy  out  1  compare/commit sequence in progress

## Operation
- States: IDLE, PLAY, CMP, COMMIT, SHOW.
- Reset:
  - state IDLE.
  - All score digits, hi digits, new_hi and busy are 0.
  - Reset overrides every other input in the same cycle, including mid-sequence (CMP/COMMIT); no partial commit.
- IDLE / SHOW:
  - Score holds.
  - start: score <= 0000, new_hi <= 0, next PLAY.
  - clear_hi: hi <= 0000, new_hi <= 0.
  - start and clear_hi together: both take effect.
- PLAY:
  - point: BCD increment.
    - Digit at 9 wraps to 0 and carries into the next digit.
    - At 9999 the increment is ignored (saturate).
  - game_over: next CMP.
  - point and game_over in the same cycle: the point is counted, then CMP.
- CMP: register greater = (score > hi) as a 4-digit magnitude compare, most-significant digit first. Next COMMIT if greater, else SHOW.
- COMMIT: hi <= score, new_hi <= 1, next SHOW.
- Ignored inputs:
  - start outside IDLE/SHOW.
  - point and game_over outside PLAY.
  - clear_hi outside IDLE/SHOW.
- Equal scores are not a new high score: hi unchanged, new_hi stays 0.
- busy = 1 exactly in CMP and COMMIT.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- point sampled at edge k: score updates after edge k.
- game_over sampled at edge k:
  - state CMP after edge k; busy high from then on.
  - After edge k+1: COMMIT (greater) or SHOW (not greater).
  - Greater: hi and new_hi update after edge k+2, state SHOW, busy low.
  - Not greater: busy low after edge k+1.
- start at edge k: score shows 0000 after edge k. A point at edge k+1 is counted.
- Compare result is taken from registered score/hi values in CMP. Inputs during CMP/COMMIT cannot alter it.

## Structure
- Package highscore_pkg:
  - State enum typedef.
  - bcd_t (logic [3:0]).
  - Constants BCD_MAX = 4'd9 and SCORE_MAX digits (9,9,9,9).
- Sub-module score_cmp:
  - Purely combinational 4-digit BCD magnitude comparator.
  - Inputs: two digit sets. Output: a strict greater-than flag.
  - Instantiated once, its output registered in CMP.
- BCD increment with carry chain and saturation is a function in highscore_pkg.

## Test plan
- Reset then idle: all outputs 0, state IDLE. start, 3 points, game_over → score 0003; after edge k+2, hi = 0003 and new_hi = 1; busy high exactly 2 cycles.
- Carry and saturation:
  - Preload score 0009, point → 0010.
  - 0999, point → 1000.
  - 9999, point → 9999 unchanged.
- Not greater: hi = 0005, play to 0005, game_over → hi stays 0005, new_hi = 0, SHOW after edge k+1. Repeat with 0004 → same result.
- Digit priority: hi = 0990, score 1000 → commit, hi = 1000. hi = 1000, score 0999 → no commit.
- Simultaneous and ignored events:
  - point with game_over at score 0041 → final 0042, compared.
  - start during PLAY → ignored.
  - clear_hi during CMP → ignored.
  - clear_hi with start in SHOW → hi 0000, score 0000, PLAY.
- Reset mid-operation: assert reset in CMP and in COMMIT → next cycle all outputs 0, IDLE, hi not written.

Source files
------------

// File: rtl/highscore_pkg.sv
// Shared types, constants and the BCD increment helper for the score/high-score path.
// The score is held as four packed BCD digits, index 3 being the most significant.
package highscore_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_CMP,
        ST_COMMIT,
        ST_SHOW
    } state_t;

    typedef logic [3:0] bcd_t;
    typedef bcd_t [3:0] score_t;

    localparam bcd_t   BCD_MAX   = 4'd9;
    localparam bcd_t   BCD_ZERO  = 4'd0;
    localparam score_t SCORE_MAX = {4'd9, 4'd9, 4'd9, 4'd9};
    localparam score_t SCORE_ZERO = {4'd0, 4'd0, 4'd0, 4'd0};

    // Ripple a +1 up from the least significant digit; 9999 saturates.
    function automatic score_t bcd_inc(input score_t s);
        score_t r;
        logic   carry;
        r     = s;
        carry = 1'b1;
        if (s == SCORE_MAX) begin
            return s;
        end
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (s[i] >= BCD_MAX) begin
                    r[i]  = BCD_ZERO;
                    carry = 1'b1;
                end else begin
                    r[i]  = s[i] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/highscore_ctrl_score_cmp.sv
// Combinational 4-digit BCD magnitude comparator: o_greater is 1 only when i_a > i_b.
// The most significant differing digit decides; equal values are not greater.
module score_cmp
    import highscore_pkg::*;
(
    input  score_t i_a,
    input  score_t i_b,
    output logic   o_greater
);

    logic w_greater;
    logic w_decided;

    always_comb begin
        w_greater = 1'b0;
        w_decided = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!w_decided && (i_a[i] != i_b[i])) begin
                w_greater = (i_a[i] > i_b[i]);
                w_decided = 1'b1;
            end
        end
    end

    assign o_greater = w_greater;

endmodule

// File: rtl/highscore_ctrl.sv
// Score/high-score sequencer: counts BCD points during play, then compares the final
// score with the stored high score and commits it only when strictly greater.
module highscore_ctrl
    import highscore_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       point,
    input  logic       game_over,
    input  logic       clear_hi,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [3:0] score3,
    output logic [3:0] hi0,
    output logic [3:0] hi1,
    output logic [3:0] hi2,
    output logic [3:0] hi3,
    output logic       new_hi,
    output logic       busy
);

    state_t r_state;
    score_t r_score;
    score_t r_hi;
    logic   r_new_hi;
    logic   r_busy;
    logic   r_greater;
    logic   w_greater;

    score_cmp u_score_cmp (
        .i_a       (r_score),
        .i_b       (r_hi),
        .o_greater (w_greater)
    );

    // Single registered FSM; busy is set on entry to CMP and dropped on entry to SHOW.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_score   <= SCORE_ZERO;
            r_hi      <= SCORE_ZERO;
            r_new_hi  <= 1'b0;
            r_busy    <= 1'b0;
            r_greater <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_SHOW: begin
                    if (clear_hi) begin
                        r_hi     <= SCORE_ZERO;
                        r_new_hi <= 1'b0;
                    end
                    if (start) begin
                        r_score  <= SCORE_ZERO;
                        r_new_hi <= 1'b0;
                        r_state  <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (point) begin
                        r_score <= bcd_inc(r_score);
                    end
                    if (game_over) begin
                        r_state <= ST_CMP;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CMP: begin
                    r_greater <= w_greater;
                    if (w_greater) begin
                        r_state <= ST_COMMIT;
                    end else begin
                        r_state <= ST_SHOW;
                        r_busy  <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    if (r_greater) begin
                        r_hi     <= r_score;
                        r_new_hi <= 1'b1;
                    end
                    r_state <= ST_SHOW;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign score0 = r_score[0];
    assign score1 = r_score[1];
    assign score2 = r_score[2];
    assign score3 = r_score[3];
    assign hi0    = r_hi[0];
    assign hi1    = r_hi[1];
    assign hi2    = r_hi[2];
    assign hi3    = r_hi[3];
    assign new_hi = r_new_hi;
    assign busy   = r_busy;

endmodule

// File: tb/tb_highscore_ctrl.sv
// Self-checking bench for highscore_ctrl: a decimal behavioural model pushes the expected
// outputs for every driven cycle into a queue, which is popped and compared after the edge.
module tb_highscore_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       point = 1'b0;
    logic       game_over = 1'b0;
    logic       clear_hi = 1'b0;
    logic [3:0] score0, score1, score2, score3;
    logic [3:0] hi0, hi1, hi2, hi3;
    logic       new_hi;
    logic       busy;

    typedef enum {M_IDLE, M_PLAY, M_CMP, M_COMMIT, M_SHOW} model_state_t;

    typedef struct {
        logic [15:0] score;
        logic [15:0] hi;
        logic        newHi;
        logic        busy;
    } expect_t;

    expect_t      sbQueue[$];
    model_state_t mState = M_IDLE;
    int           mScore = 0;
    int           mHi = 0;
    logic         mNewHi = 1'b0;
    int           compareCount = 0;
    int           mismatchCount = 0;

    highscore_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .point     (point),
        .game_over (game_over),
        .clear_hi  (clear_hi),
        .score0    (score0),
        .score1    (score1),
        .score2    (score2),
        .score3    (score3),
        .hi0       (hi0),
        .hi1       (hi1),
        .hi2       (hi2),
        .hi3       (hi3),
        .new_hi    (new_hi),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] toBcd(input int v);
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'((v / 1000) % 10);
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d3, d2, d1, d0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance the model one cycle, push its prediction, clock the DUT, then pop and compare.
    task automatic applyStimulus(input logic st, input logic pt, input logic go,
                                 input logic clr, input logic rst);
        expect_t e;
        expect_t got;
        if (rst) begin
            mState = M_IDLE;
            mScore = 0;
            mHi    = 0;
            mNewHi = 1'b0;
        end else begin
            case (mState)
                M_IDLE, M_SHOW: begin
                    if (clr) begin
                        mHi    = 0;
                        mNewHi = 1'b0;
                    end
                    if (st) begin
                        mScore = 0;
                        mNewHi = 1'b0;
                        mState = M_PLAY;
                    end
                end
                M_PLAY: begin
                    if (pt && mScore < 9999) mScore++;
                    if (go) mState = M_CMP;
                end
                M_CMP:    mState = (mScore > mHi) ? M_COMMIT : M_SHOW;
                M_COMMIT: begin
                    mHi    = mScore;
                    mNewHi = 1'b1;
                    mState = M_SHOW;
                end
                default:  mState = M_IDLE;
            endcase
        end
        e.score = toBcd(mScore);
        e.hi    = toBcd(mHi);
        e.newHi = mNewHi;
        e.busy  = (mState == M_CMP) || (mState == M_COMMIT);
        sbQueue.push_back(e);

        start     = st;
        point     = pt;
        game_over = go;
        clear_hi  = clr;
        reset     = rst;
        @(posedge clk);
        #1;
        if (sbQueue.size() == 0) begin
            checkOutput("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sbQueue.pop_front();
            checkOutput("score",  {16'd0, score3, score2, score1, score0}, {16'd0, got.score});
            checkOutput("hi",     {16'd0, hi3, hi2, hi1, hi0},             {16'd0, got.hi});
            checkOutput("new_hi", {31'd0, new_hi},                        {31'd0, got.newHi});
            checkOutput("busy",   {31'd0, busy},                          {31'd0, got.busy});
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic playPoints(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic playGame(input int n);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        playPoints(n);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(3);
    endtask

    function automatic logic [31:0] scoreNow();
        return {16'd0, score3, score2, score1, score0};
    endfunction

    function automatic logic [31:0] hiNow();
        return {16'd0, hi3, hi2, hi1, hi0};
    endfunction

    initial begin
        // Reset and idle
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_score", scoreNow(), 32'h0);
        checkOutput("reset_hi", hiNow(), 32'h0);
        idleCycles(2);

        // Basic game: three points, new high score after edge k+2
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        playPoints(3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("busy_k", {31'd0, busy}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("busy_k1", {31'd0, busy}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("hi_0003", hiNow(), 32'h0003);
        checkOutput("new_hi_set", {31'd0, new_hi}, 32'd1);
        checkOutput("busy_k2", {31'd0, busy}, 32'd0);
        idleCycles(1);

        // Carry chain and saturation
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        playPoints(9);
        checkOutput("score_0009", scoreNow(), 32'h0009);
        playPoints(1);
        checkOutput("score_0010", scoreNow(), 32'h0010);
        playPoints(989);
        checkOutput("score_0999", scoreNow(), 32'h0999);
        playPoints(1);
        checkOutput("score_1000", scoreNow(), 32'h1000);
        playPoints(8999);
        checkOutput("score_9999", scoreNow(), 32'h9999);
        playPoints(1);
        checkOutput("score_sat", scoreNow(), 32'h9999);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(3);

        // Equal and lower scores do not replace the high score
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        playGame(5);
        checkOutput("hi_0005", hiNow(), 32'h0005);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        playPoints(5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("equal_busy_low", {31'd0, busy}, 32'd0);
        checkOutput("equal_new_hi", {31'd0, new_hi}, 32'd0);
        idleCycles(2);
        playGame(4);
        checkOutput("lower_hi", hiNow(), 32'h0005);

        // Digit priority
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        playGame(990);
        playGame(1000);
        checkOutput("hi_1000", hiNow(), 32'h1000);
        playGame(999);
        checkOutput("hi_kept_1000", hiNow(), 32'h1000);

        // Ignored start in PLAY, point with game_over, clear_hi during CMP
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        playPoints(20);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        playPoints(21);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("score_0042", scoreNow(), 32'h0042);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("clr_in_cmp", hiNow(), 32'h1000);
        idleCycles(2);

        // clear_hi together with start in SHOW
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("clr_start_hi", hiNow(), 32'h0000);
        playPoints(1);
        checkOutput("play_after_clr", scoreNow(), 32'h0001);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(3);

        // Reset in CMP and in COMMIT
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        playPoints(2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_cmp_hi", hiNow(), 32'h0);
        idleCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        playPoints(3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_commit_hi", hiNow(), 32'h0);
        checkOutput("rst_commit_new_hi", {31'd0, new_hi}, 32'd0);
        idleCycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
